// File: rtl/sumres_bcd_scan.sv
// Add/subtract unit with sign-magnitude result, sequential double-dabble BCD
// conversion and a multiplexed NDIG-position seven-segment display driver.
module sumres_bcd_scan #(
   parameter int W           = 8,
   parameter int NDIG        = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [W-1:0]    A,
   input  logic [W-1:0]    B,
   input  logic            sub,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic            ovf,
   output logic [6:0]      SSeg,
   output logic [NDIG-1:0] an
);

   localparam int MW     = W + 1;
   localparam int ND     = NDIG - 1;
   // 2^(3k) < 10^k, so ceil(MW/3) nibbles always hold the full magnitude
   localparam int NB_MIN = (MW + 2) / 3;
   localparam int NB     = (ND > NB_MIN) ? ND : NB_MIN;
   localparam int CVW    = $clog2(W + 1);
   localparam int SCW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int PW     = $clog2(NDIG);

   localparam logic [CVW-1:0] CONV_LAST = CVW'(W);
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0]  POS_LAST  = PW'(NDIG - 1);

   localparam logic [6:0] SEG_E     = 7'b1111001;
   localparam logic [6:0] SEG_MINUS = 7'b1000000;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

   localparam logic [63:0] OVF_THR = pow10(ND);

   function automatic logic [6:0] dec7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_CONV,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic              sub_q, sub_d;
   logic [MW-1:0]     mag_q, mag_d;
   logic              neg_q, neg_d;
   logic              ovf_next_q, ovf_next_d;
   logic [4*NB-1:0]   bcd_q, bcd_d;
   logic [CVW-1:0]    cnt_q, cnt_d;
   logic [4*ND-1:0]   disp_bcd_q, disp_bcd_d;
   logic              disp_neg_q, disp_neg_d;
   logic              ovf_q, ovf_d;

   logic [MW-1:0]     mag_calc;
   logic              neg_calc;
   logic [4*NB-2:0]   bcd_adj;

   always_comb begin
      mag_calc = {1'b0, a_q} + {1'b0, b_q};
      neg_calc = 1'b0;
      if (sub_q) begin
         if (a_q < b_q) begin
            mag_calc = {1'b0, b_q} - {1'b0, a_q};
            neg_calc = 1'b1;
         end else begin
            mag_calc = {1'b0, a_q} - {1'b0, b_q};
         end
      end
   end

   // Add-3 correction; the top nibble keeps only the 3 bits that survive the shift
   genvar gi;
   generate
      for (gi = 0; gi < NB - 1; gi++) begin : g_adj
         assign bcd_adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ?
                                     bcd_q[4*gi +: 4] + 4'd3 : bcd_q[4*gi +: 4];
      end
   endgenerate

   assign bcd_adj[4*NB-2 : 4*(NB-1)] = (bcd_q[4*NB-1 -: 4] >= 4'd5) ?
                                       3'(bcd_q[4*NB-1 -: 4] + 4'd3) :
                                       bcd_q[4*NB-2 -: 3];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      sub_d      = sub_q;
      mag_d      = mag_q;
      neg_d      = neg_q;
      ovf_next_d = ovf_next_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      disp_bcd_d = disp_bcd_q;
      disp_neg_d = disp_neg_q;
      ovf_d      = ovf_q;
      busy       = (state_q != S_IDLE);
      done       = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               sub_d   = sub;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            mag_d      = mag_calc;
            neg_d      = neg_calc;
            ovf_next_d = (64'(mag_calc) >= OVF_THR);
            bcd_d      = '0;
            cnt_d      = '0;
            state_d    = S_CONV;
         end
         S_CONV: begin
            bcd_d = {bcd_adj, mag_q[MW-1]};
            mag_d = {mag_q[MW-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CONV_LAST) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            disp_bcd_d = bcd_q[4*ND-1:0];
            disp_neg_d = neg_q;
            ovf_d      = ovf_next_q;
            done       = 1'b1;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q        <= '0;
         b_q        <= '0;
         sub_q      <= 1'b0;
         mag_q      <= '0;
         neg_q      <= 1'b0;
         ovf_next_q <= 1'b0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         disp_bcd_q <= '0;
         disp_neg_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         a_q        <= a_d;
         b_q        <= b_d;
         sub_q      <= sub_d;
         mag_q      <= mag_d;
         neg_q      <= neg_d;
         ovf_next_q <= ovf_next_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         disp_bcd_q <= disp_bcd_d;
         disp_neg_q <= disp_neg_d;
         ovf_q      <= ovf_d;
      end
   end

   assign ovf = ovf_q;

   // Segment pattern for every position, precomputed so the scan only muxes
   logic [6:0] seg_pos [NDIG];

   generate
      for (gi = 0; gi < ND; gi++) begin : g_pos
         logic blank;
         if (gi == 0) begin : g_units
            assign blank = 1'b0;
         end else begin : g_upper
            assign blank = (disp_bcd_q[4*ND-1 : 4*gi] == '0);
         end
         assign seg_pos[gi] = ovf_q ? SEG_E :
                              blank ? SEG_BLANK : dec7(disp_bcd_q[4*gi +: 4]);
      end
   endgenerate

   assign seg_pos[ND] = disp_neg_q ? SEG_MINUS : SEG_BLANK;

   logic [SCW-1:0]  scan_cnt_q, scan_cnt_d;
   logic [PW-1:0]   pos_q, pos_d;
   logic [NDIG-1:0] an_q, an_d;
   logic [6:0]      seg_q, seg_d;

   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      pos_d      = pos_q;
      if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_d = '0;
         pos_d      = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
      end
      // Enable and data both follow the next index so they switch together
      an_d  = {{(NDIG-1){1'b0}}, 1'b1} << pos_d;
      seg_d = seg_pos[pos_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt_q <= '0;
         pos_q      <= '0;
         an_q       <= {{(NDIG-1){1'b0}}, 1'b1};
         seg_q      <= dec7(4'd0);
      end else begin
         scan_cnt_q <= scan_cnt_d;
         pos_q      <= pos_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign SSeg = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
   assign an   = (ACTIVE_LOW != 0) ? ~an_q  : an_q;

endmodule

// File: tb/tb_sumres_bcd_scan.sv
// Scoreboard bench: expected display contents are queued at start and compared
// when the unit pulses done; display is read back by following the scan.
module tb_sumres_bcd_scan;

   localparam int W = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
   logic       sub0 = 1'b0, sub1 = 1'b0, start0 = 1'b0, start1 = 1'b0;
   logic       busy0, done0, ovf0, busy1, done1, ovf1;
   logic [6:0] sseg0, sseg1;
   logic [3:0] an0;
   logic [2:0] an1;

   always #5 clk = ~clk;

   sumres_bcd_scan #(.W(W), .NDIG(4), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut (
      .clk(clk), .rst(rst), .A(a0), .B(b0), .sub(sub0), .start(start0),
      .busy(busy0), .done(done0), .ovf(ovf0), .SSeg(sseg0), .an(an0)
   );

   sumres_bcd_scan #(.W(W), .NDIG(3), .REFRESH_DIV(4), .ACTIVE_LOW(1)) dut3 (
      .clk(clk), .rst(rst), .A(a1), .B(b1), .sub(sub1), .start(start1),
      .busy(busy1), .done(done1), .ovf(ovf1), .SSeg(sseg1), .an(an1)
   );

   typedef struct packed {
      logic            ovf;
      logic [3:0][6:0] seg;
   } exp_t;

   exp_t            sb_q[$];
   int              n_checks = 0;
   int              n_pass = 0;
   logic [3:0][6:0] cap;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   // Active-low segment patterns, g..a from left
   function automatic logic [6:0] dig_al(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic exp_t model(input int a, input int b, input bit s, input int nd);
      exp_t e;
      int   m, thr, pw;
      bit   neg;
      thr = 1;
      for (int i = 0; i < nd - 1; i++) thr = thr * 10;
      neg = s && (a < b);
      m   = !s ? a + b : (a >= b ? a - b : b - a);
      e.ovf = (m >= thr);
      e.seg = '1;
      e.seg[nd-1] = neg ? 7'b0111111 : 7'b1111111;
      pw = 1;
      for (int p = 0; p < nd - 1; p++) begin
         if (e.ovf) e.seg[p] = 7'b0000110;
         else if (p > 0 && (m / pw) == 0) e.seg[p] = 7'b1111111;
         else e.seg[p] = dig_al((m / pw) % 10);
         pw = pw * 10;
      end
      return e;
   endfunction

   task automatic capture(input int sel);
      int nd;
      nd = (sel != 0) ? 3 : 4;
      cap = '1;
      for (int p = 0; p < nd; p++) cap[p] = 'x;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         for (int p = 0; p < nd; p++) begin
            if (sel == 0 && an0 == ~(4'b1 << p)) cap[p] = sseg0;
            if (sel != 0 && an1 == ~(3'b1 << p)) cap[p] = sseg1;
         end
      end
   endtask

   task automatic compare_display(input string tag, input exp_t e);
      for (int p = 0; p < 4; p++) begin
         check($sformatf("%s_pos%0d", tag, p), {25'd0, cap[p]}, {25'd0, e.seg[p]});
      end
   endtask

   // mode 0: plain; 1: extra start during CONV; 2: reset with start during CONV
   task automatic run_op(input int sel, input int a, input int b, input bit s, input int mode);
      exp_t e, got_e;
      int   lat, ndone;
      logic d, bz, ov;
      lat   = -1;
      ndone = 0;
      got_e = '0;
      e = model(a, b, s, (sel != 0) ? 3 : 4);
      if (mode != 2) sb_q.push_back(e);
      @(negedge clk);
      if (sel == 0) begin a0 = 8'(a); b0 = 8'(b); sub0 = s; start0 = 1'b1; end
      else          begin a1 = 8'(a); b1 = 8'(b); sub1 = s; start1 = 1'b1; end
      for (int i = 1; i <= 24; i++) begin
         @(negedge clk);
         d  = (sel == 0) ? done0 : done1;
         bz = (sel == 0) ? busy0 : busy1;
         if (d) begin
            ndone++;
            if (lat < 0) begin
               lat = i;
               if (sb_q.size() > 0) got_e = sb_q.pop_front();
            end
         end
         if (i == 1) begin
            check("busy_first", {31'd0, bz}, 32'd1);
            start0 = 1'b0; start1 = 1'b0;
            a0 = 8'($urandom); b0 = 8'($urandom); sub0 = ~sub0;
            a1 = 8'($urandom); b1 = 8'($urandom); sub1 = ~sub1;
         end
         if (mode == 1 && i == 4) begin a0 = 8'd1; b0 = 8'd1; start0 = 1'b1; end
         if (mode == 1 && i == 5) start0 = 1'b0;
         if (mode == 2 && i == 5) begin rst = 1'b1; start0 = 1'b1; end
         if (mode == 2 && i == 6) begin
            check("abort_busy", {31'd0, busy0}, 32'd0);
            check("abort_done", {31'd0, done0}, 32'd0);
            rst = 1'b0; start0 = 1'b0;
         end
      end
      ov = (sel == 0) ? ovf0 : ovf1;
      $display("txn dut%0d A=%0d B=%0d sub=%0b mode=%0d lat=%0d ndone=%0d ovf=%0b",
               sel, a, b, s, mode, lat, ndone, ov);
      if (mode == 2) begin
         check("abort_no_done", ndone, 0);
         check("abort_ovf", {31'd0, ov}, 32'd0);
         capture(0);
         compare_display("abort", model(0, 0, 1'b0, 4));
      end else begin
         check("latency", lat, W + 3);
         check("done_once", ndone, 1);
         check("busy_after", {31'd0, bz}, 32'd0);
         check("ovf", {31'd0, ov}, {31'd0, got_e.ovf});
         capture(sel);
         compare_display($sformatf("res%0d_%0d", a, b), got_e);
      end
   endtask

   function automatic int an_index(input logic [3:0] v);
      for (int p = 0; p < 4; p++) if (v == ~(4'b1 << p)) return p;
      return -1;
   endfunction

   task automatic scan_check();
      int prev, len, trans, idx;
      prev = -1; len = 0; trans = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         idx = an_index(an0);
         if (idx < 0) check("scan_onehot", {28'd0, an0}, 32'd0);
         if (idx != prev) begin
            if (prev >= 0) begin
               if (trans > 0) check("scan_len", len, 4);
               check("scan_order", idx, (prev + 1) % 4);
               trans++;
            end
            prev = idx;
            len  = 1;
         end else begin
            len++;
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_an", {28'd0, an0}, 32'b1110);
      check("rst_seg", {25'd0, sseg0}, 32'b1000000);
      repeat (20) @(negedge clk);
      check("idle_busy", {31'd0, busy0}, 32'd0);
      check("idle_done", {31'd0, done0}, 32'd0);
      check("idle_ovf", {31'd0, ovf0}, 32'd0);
      capture(0);
      compare_display("reset", model(0, 0, 1'b0, 4));
      scan_check();

      run_op(0, 200, 100, 1'b0, 0);
      run_op(0, 5, 20, 1'b1, 0);
      run_op(0, 7, 7, 1'b1, 0);
      run_op(0, 255, 255, 1'b0, 0);
      run_op(1, 100, 0, 1'b0, 0);
      run_op(1, 9, 0, 1'b0, 0);
      run_op(0, 123, 45, 1'b1, 1);
      run_op(0, 250, 3, 1'b0, 2);
      check("sb_empty", sb_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
